riscv_hwloop_regs: RTL and testbench
====================================

# riscv_hwloop_regs

Hardware-loop register file for the RI5CY ID stage: holds start address, end address and iteration counter for each of N_REGS loops, and drives them continuously to the hardware-loop controller. It accepts writes from `lp.*` setup instructions and CSR writes. It applies the counter decrements requested by the controller. It also provides a registered CSR readback path.

## Interface
- N_REGS, 2, number of hardware loops (1..4).
- N_REG_BITS, $clog2(N_REGS) (min 1), width of loop index.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hwlp_start_data_i  in  32  start address write data.
- hwlp_end_data_i  in  32  end address write data.
- hwlp_cnt_data_i  in  32  counter write data.
- hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] counter.
- hwlp_regid_i  in  N_REG_BITS  target loop for writes.
- valid_i  in  1  ID instruction valid; gates decrements.
- hwlp_dec_cnt_i  in  N_REGS  per-loop decrement request from controller.
- csr_rd_en_i  in  1  CSR readback request.
- csr_rd_sel_i  in  2  readback field: 0 start, 1 end, 2 counter, 3 reserved.
- csr_rd_regid_i  in  N_REG_BITS  readback loop index.
- hwlp_start_addr_o  out  N_REGS×32  start addresses.
- hwlp_end_addr_o  out  N_REGS×32  end addresses.
- hwlp_counter_o  out  N_REGS×32  counters.
- hwlp_active_o  out  N_REGS  counter != 0, registered.
- csr_rdata_o  out  32  readback data.
- csr_rvalid_o  out  1  readback data valid pulse.

## Operation
- Storage: three 32-bit registers per loop. The start and end address registers store bits [31:1]; bit 0 always reads 0.
- Writes:
  - Each asserted hwlp_we_i bit writes its field of loop hwlp_regid_i at the next clk edge.
  - Writes are not gated by valid_i.
  - Any combination of enables may be set in one cycle (lp.setup sets all three).
- Decrement:
  - Loop i counter becomes counter−1 when valid_i && hwlp_dec_cnt_i[i].
  - A counter at 0 stays 0 (saturates, no wrap).
  - Several loops may decrement in the same cycle.
- Same-cycle collision: if hwlp_we_i[2] targets loop i and loop i also decrements, the write wins and the decrement is dropped. Start/end writes never collide with decrements.
- hwlp_regid_i ≥ N_REGS: the write is ignored.
- hwlp_active_o[i]: registered; equals (next counter value != 0).
- CSR read:
  - csr_rd_en_i registers the selected field into csr_rdata_o and pulses csr_rvalid_o for one cycle.
  - csr_rd_sel_i=3 or an out-of-range regid returns 0, with rvalid still asserted.
  - Readback returns the pre-update value when a write lands in the same cycle.
- No state machine beyond the per-loop registers and the readback stage; readback is single-issue per cycle and fully pipelined, with no backpressure.

## Timing
- Reset (rst_n low, async):
  - All start, end and counter registers = 0.
  - hwlp_active_o = 0.
  - csr_rdata_o = 0, csr_rvalid_o = 0.
- Write latency: 1 cycle. Data presented in cycle n is visible on the outputs in cycle n+1.
- Decrement latency: 1 cycle. The controller sees the new count in the next cycle, so it must not rely on same-cycle feedback.
- Readback latency: 1 cycle, from csr_rd_en_i to csr_rvalid_o/csr_rdata_o.
- Reset asserted mid-operation clears all state immediately. Operations pending at the next edge are discarded.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs.

## Test plan
- Reset check: drive rst_n low at an arbitrary time with nonzero contents -> all outputs read 0 asynchronously, before the next clk edge.
- Setup: hwlp_we_i=3'b111, regid=1, start=0x100, end=0x120, cnt=5 -> next cycle loop1 start=0x100, end=0x120, counter=5, active[1]=1; loop0 unchanged.
- Decrement chain: counter=2, hold valid_i=1 with hwlp_dec_cnt_i[0]=1 for 3 cycles -> counter reads 1, 0, 0; active[0] falls together with counter=0.
- Valid gating: dec_cnt[0]=1 with valid_i=0 -> counter unchanged.
- Collision: counter write of 7 to loop0 in the same cycle as a loop0 decrement -> counter=7. A simultaneous loop1 decrement is still applied.
- Readback: csr_rd_en_i with sel=1, regid=1 after setup -> one cycle later rdata=0x120, rvalid=1 for exactly one cycle. Sel=3 -> rdata=0, rvalid=1.

Source files
------------

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: start/end/counter per loop,
// controller decrements, lp.* and CSR writes, registered CSR readback.
module riscv_hwloop_regs #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                hwlp_start_data_i,
  input  logic [31:0]                hwlp_end_data_i,
  input  logic [31:0]                hwlp_cnt_data_i,
  input  logic [2:0]                 hwlp_we_i,
  input  logic [N_REG_BITS-1:0]      hwlp_regid_i,
  input  logic                       valid_i,
  input  logic [N_REGS-1:0]          hwlp_dec_cnt_i,
  input  logic                       csr_rd_en_i,
  input  logic [1:0]                 csr_rd_sel_i,
  input  logic [N_REG_BITS-1:0]      csr_rd_regid_i,
  output logic [N_REGS-1:0][31:0]    hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0]    hwlp_end_addr_o,
  output logic [N_REGS-1:0][31:0]    hwlp_counter_o,
  output logic [N_REGS-1:0]          hwlp_active_o,
  output logic [31:0]                csr_rdata_o,
  output logic                       csr_rvalid_o
);

  logic [N_REGS-1:0][31:1] start_q;
  logic [N_REGS-1:0][31:1] end_q;
  logic [N_REGS-1:0][31:0] cnt_q;
  logic [N_REGS-1:0][31:0] cnt_d;
  logic [N_REGS-1:0]       active_q;
  logic [N_REGS-1:0]       wr_hit;
  logic [31:0]             rdata_q;
  logic [31:0]             rdata_d;
  logic                    rvalid_q;

  // Out-of-range regids simply match no loop
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_REGS; i++) begin
      wr_hit[i] = (int'(hwlp_regid_i) == i);
    end
  end

  // A counter write overrides a same-cycle decrement
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REGS; i++) begin
      if (hwlp_we_i[2] && wr_hit[i]) begin
        cnt_d[i] = hwlp_cnt_data_i;
      end else if (valid_i && hwlp_dec_cnt_i[i]
                   && cnt_q[i] != 32'd0) begin
        cnt_d[i] = cnt_q[i] - 32'd1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (int'(csr_rd_regid_i) == i) begin
        unique case (csr_rd_sel_i)
          2'd0:    rdata_d = {start_q[i], 1'b0};
          2'd1:    rdata_d = {end_q[i], 1'b0};
          2'd2:    rdata_d = cnt_q[i];
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (hwlp_we_i[0] && wr_hit[i]) begin
          start_q[i] <= hwlp_start_data_i[31:1];
        end
        if (hwlp_we_i[1] && wr_hit[i]) begin
          end_q[i] <= hwlp_end_data_i[31:1];
        end
        active_q[i] <= (cnt_d[i] != 32'd0);
      end
      cnt_q    <= cnt_d;
      rvalid_q <= csr_rd_en_i;
      if (csr_rd_en_i) begin
        rdata_q <= rdata_d;
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign hwlp_start_addr_o[g] = {start_q[g], 1'b0};
    assign hwlp_end_addr_o[g]   = {end_q[g], 1'b0};
  end

  assign hwlp_counter_o = cnt_q;
  assign hwlp_active_o  = active_q;
  assign csr_rdata_o    = rdata_q;
  assign csr_rvalid_o   = rvalid_q;

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Testbench for riscv_hwloop_regs: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_riscv_hwloop_regs;

  localparam int N  = 2;
  localparam int NB = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       start_data = '0;
  logic [31:0]       end_data = '0;
  logic [31:0]       cnt_data = '0;
  logic [2:0]        we = '0;
  logic [NB-1:0]     regid = '0;
  logic              valid = 1'b0;
  logic [N-1:0]      dec = '0;
  logic              rd_en = 1'b0;
  logic [1:0]        rd_sel = '0;
  logic [NB-1:0]     rd_regid = '0;
  logic [N-1:0][31:0] start_addr;
  logic [N-1:0][31:0] end_addr;
  logic [N-1:0][31:0] counter;
  logic [N-1:0]      active;
  logic [31:0]       rdata;
  logic              rvalid;

  int passed = 0;
  int total = 0;

  int unsigned m_start[N];
  int unsigned m_end[N];
  int unsigned m_cnt[N];
  bit          m_act[N];
  int unsigned m_rdata;
  bit          m_rvalid;

  always #5 clk = ~clk;

  riscv_hwloop_regs #(.N_REGS(N), .N_REG_BITS(NB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hwlp_start_data_i(start_data),
    .hwlp_end_data_i(end_data),
    .hwlp_cnt_data_i(cnt_data),
    .hwlp_we_i(we),
    .hwlp_regid_i(regid),
    .valid_i(valid),
    .hwlp_dec_cnt_i(dec),
    .csr_rd_en_i(rd_en),
    .csr_rd_sel_i(rd_sel),
    .csr_rd_regid_i(rd_regid),
    .hwlp_start_addr_o(start_addr),
    .hwlp_end_addr_o(end_addr),
    .hwlp_counter_o(counter),
    .hwlp_active_o(active),
    .csr_rdata_o(rdata),
    .csr_rvalid_o(rvalid)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_start[i] = 0;
      m_end[i] = 0;
      m_cnt[i] = 0;
      m_act[i] = 0;
    end
    m_rdata = 0;
    m_rvalid = 0;
  endtask

  // Apply the architectural rules to the inputs of the coming edge
  task automatic model_cycle();
    int unsigned ns[N], ne[N], nc[N];
    int r = int'(regid);
    int rr = int'(rd_regid);
    if (rd_en) begin
      if (rd_sel == 2'd3 || rr >= N) m_rdata = 0;
      else if (rd_sel == 2'd0) m_rdata = m_start[rr];
      else if (rd_sel == 2'd1) m_rdata = m_end[rr];
      else m_rdata = m_cnt[rr];
    end
    m_rvalid = rd_en;
    for (int i = 0; i < N; i++) begin
      ns[i] = m_start[i];
      ne[i] = m_end[i];
      nc[i] = m_cnt[i];
      if (valid && dec[i] && nc[i] > 0) nc[i] = nc[i] - 1;
      if (r == i) begin
        if (we[0]) ns[i] = start_data & 32'hFFFF_FFFE;
        if (we[1]) ne[i] = end_data & 32'hFFFF_FFFE;
        if (we[2]) nc[i] = cnt_data;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_start[i] = ns[i];
      m_end[i] = ne[i];
      m_cnt[i] = nc[i];
      m_act[i] = (nc[i] != 0);
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = '0;
    valid = 1'b0;
    dec = '0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({start_addr, end_addr, counter} !== '0) begin
      $display("FAIL reset_regs got %h want 0",
               {start_addr, end_addr, counter});
    end else passed++;
    total++;
    if ({active, rdata, rvalid} !== '0) begin
      $display("FAIL reset_out got %h want 0", {active, rdata, rvalid});
    end else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_setup();
    we = 3'b111;
    regid = 1'b1;
    start_data = 32'h100;
    end_data = 32'h120;
    cnt_data = 32'd5;
    step();
    idle_inputs();
    total++;
    if (start_addr[1] !== 32'h100 || end_addr[1] !== 32'h120) begin
      $display("FAIL setup_addr got %h/%h want 100/120",
               start_addr[1], end_addr[1]);
    end else passed++;
    total++;
    if (counter[1] !== 32'd5 || active[1] !== 1'b1) begin
      $display("FAIL setup_cnt got %0d/%b want 5/1",
               counter[1], active[1]);
    end else passed++;
    total++;
    if (start_addr[0] !== '0 || end_addr[0] !== '0 ||
        counter[0] !== '0) begin
      $display("FAIL setup_loop0 got %h %h %h want 0",
               start_addr[0], end_addr[0], counter[0]);
    end else passed++;
    // Bit 0 of addresses is never stored
    we = 3'b011;
    regid = 1'b0;
    start_data = 32'h201;
    end_data = 32'h3FF;
    step();
    idle_inputs();
    total++;
    if (start_addr[0] !== 32'h200 || end_addr[0] !== 32'h3FE) begin
      $display("FAIL addr_bit0 got %h/%h want 200/3fe",
               start_addr[0], end_addr[0]);
    end else passed++;
  endtask

  task automatic test_dec_chain();
    logic [31:0] exp_c[3] = '{32'd1, 32'd0, 32'd0};
    logic        exp_a[3] = '{1'b1, 1'b0, 1'b0};
    we = 3'b100;
    regid = 1'b0;
    cnt_data = 32'd2;
    step();
    idle_inputs();
    valid = 1'b1;
    dec = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (counter[0] !== exp_c[k] || active[0] !== exp_a[k]) begin
        $display("FAIL dec_chain%0d got %0d/%b want %0d/%b", k,
                 counter[0], active[0], exp_c[k], exp_a[k]);
      end else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_valid_gating();
    we = 3'b100;
    regid = 1'b0;
    cnt_data = 32'd3;
    step();
    idle_inputs();
    valid = 1'b0;
    dec = 2'b11;
    step();
    idle_inputs();
    total++;
    if (counter[0] !== 32'd3 || counter[1] !== 32'd5) begin
      $display("FAIL valid_gate got %0d/%0d want 3/5",
               counter[0], counter[1]);
    end else passed++;
  endtask

  task automatic test_collision();
    we = 3'b100;
    regid = 1'b0;
    cnt_data = 32'd7;
    valid = 1'b1;
    dec = 2'b11;
    step();
    idle_inputs();
    total++;
    if (counter[0] !== 32'd7) begin
      $display("FAIL collide_wr got %0d want 7", counter[0]);
    end else passed++;
    total++;
    if (counter[1] !== 32'd4) begin
      $display("FAIL collide_dec got %0d want 4", counter[1]);
    end else passed++;
  endtask

  task automatic test_readback();
    rd_en = 1'b1;
    rd_sel = 2'd1;
    rd_regid = 1'b1;
    step();
    idle_inputs();
    total++;
    if (rdata !== 32'h120 || rvalid !== 1'b1) begin
      $display("FAIL rd_end got %h/%b want 120/1", rdata, rvalid);
    end else passed++;
    step();
    total++;
    if (rvalid !== 1'b0) begin
      $display("FAIL rd_pulse got %b want 0", rvalid);
    end else passed++;
    rd_en = 1'b1;
    rd_sel = 2'd3;
    step();
    idle_inputs();
    total++;
    if (rdata !== 32'd0 || rvalid !== 1'b1) begin
      $display("FAIL rd_sel3 got %h/%b want 0/1", rdata, rvalid);
    end else passed++;
    // Readback sees the value before a same-cycle write
    rd_en = 1'b1;
    rd_sel = 2'd2;
    rd_regid = 1'b1;
    we = 3'b100;
    regid = 1'b1;
    cnt_data = 32'd9;
    step();
    idle_inputs();
    total++;
    if (rdata !== 32'd4 || counter[1] !== 32'd9) begin
      $display("FAIL rd_preupd got %0d/%0d want 4/9",
               rdata, counter[1]);
    end else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int k = 0; k < 400; k++) begin
      we = 3'($urandom);
      regid = NB'($urandom);
      start_data = $urandom;
      end_data = $urandom;
      cnt_data = ($urandom_range(0, 3) == 0) ? $urandom
                                             : $urandom_range(0, 4);
      valid = 1'($urandom);
      dec = N'($urandom);
      rd_en = 1'($urandom);
      rd_sel = 2'($urandom);
      rd_regid = NB'($urandom);
      step();
      for (int i = 0; i < N; i++) begin
        total++;
        if (start_addr[i] !== m_start[i] || end_addr[i] !== m_end[i] ||
            counter[i] !== m_cnt[i] || active[i] !== m_act[i]) begin
          $display("FAIL rand_loop%0d c%0d got %h %h %h %b want %h %h %h %b",
                   i, k, start_addr[i], end_addr[i], counter[i],
                   active[i], m_start[i], m_end[i], m_cnt[i], m_act[i]);
          errs++;
        end else passed++;
      end
      total++;
      if (rvalid !== m_rvalid || (m_rvalid && rdata !== m_rdata)) begin
        $display("FAIL rand_rd c%0d got %h/%b want %h/%b",
                 k, rdata, rvalid, m_rdata, m_rvalid);
        errs++;
      end else passed++;
      if (errs > 10) break;
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    we = 3'b111;
    regid = 1'b0;
    start_data = 32'h40;
    end_data = 32'h80;
    cnt_data = 32'd6;
    rd_en = 1'b1;
    rd_sel = 2'd0;
    rd_regid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({start_addr, end_addr, counter, active, rdata, rvalid} !== '0) begin
      $display("FAIL async_rst got %h want 0",
               {start_addr, end_addr, counter, active, rdata, rvalid});
    end else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({counter, active, rvalid} !== '0) begin
      $display("FAIL rst_hold got %h want 0", {counter, active, rvalid});
    end else passed++;
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_setup();
    test_dec_chain();
    test_valid_gating();
    test_collision();
    test_readback();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
